// File: rtl/wl_lut_wr.sv
// LUT table writer: streams a burst of entries into a LUT RAM write port starting at base.
// Optional load checksum is enabled by defining WL_LUT_WR_CHKSUM_EN.
module wl_lut_wr #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic [15:0]   exp_sum,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          chk_err
);

    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StFin} state_t;

    state_t        state;
    logic [AW-1:0] base_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic          hs;
    logic          last;

    assign hs   = s_valid & s_ready;
    assign last = (idx_q == len_q - LW'(1));

`ifdef WL_LUT_WR_CHKSUM_EN
    logic [15:0] sum_q;
    logic [15:0] exp_q;
    logic [15:0] sum_nxt;
    assign sum_nxt = sum_q + 16'(s_data);
`else
    logic unused_exp_sum;
    assign unused_exp_sum = ^exp_sum;
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            s_ready <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef WL_LUT_WR_CHKSUM_EN
            sum_q   <= '0;
            exp_q   <= '0;
            chk_err <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                StIdle: begin
                    // abort wins over a coincident start
                    if (start && !abort) begin
                        base_q <= base;
                        len_q  <= len;
                        idx_q  <= '0;
                        busy   <= 1'b1;
`ifdef WL_LUT_WR_CHKSUM_EN
                        sum_q   <= '0;
                        exp_q   <= exp_sum;
                        chk_err <= (len == '0) ? (exp_sum != 16'h0) : 1'b0;
`endif
                        if (len == '0) begin
                            state <= StFin;
                            done  <= 1'b1;
                        end else begin
                            state   <= StLoad;
                            s_ready <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (abort) begin
                        state   <= StIdle;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                    end else if (hs) begin
                        wr_en   <= 1'b1;
                        wr_addr <= base_q + idx_q[AW-1:0];
                        wr_data <= s_data;
                        idx_q   <= idx_q + LW'(1);
`ifdef WL_LUT_WR_CHKSUM_EN
                        sum_q   <= sum_nxt;
`endif
                        // done is registered so it lines up with the final wr_en
                        if (last) begin
                            state   <= StFin;
                            s_ready <= 1'b0;
                            done    <= 1'b1;
`ifdef WL_LUT_WR_CHKSUM_EN
                            chk_err <= (sum_nxt != exp_q);
`endif
                        end
                    end
                end
                StFin: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= StIdle;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wl_lut_wr.md
# wl_lut_wr

Table-writer engine for runtime-reloadable lookup tables (arctan, sqrt and similar non-linear functions) in the canny pipeline. Accepts a burst of table entries over a valid/ready stream. Issues registered single-cycle writes to the write port of a LUT RAM, whose read port serves lookups exactly as a single-port registered-read table does. One load is a base address plus a length, followed by that many data words. Completion is flagged with a done pulse, and the load can optionally be integrity-checked.

## Interface
Parameters:
- DW, 8, table entry width
- AW, 8, table address width; table depth is 2**AW

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse; begins a load, sampled only in IDLE
- base  input  AW  first write address, latched on start
- len  input  AW+1  number of entries, 0..2**AW, latched on start
- exp_sum  input  16  expected checksum, latched on start (used only with WL_LUT_WR_CHKSUM_EN)
- abort  input  1  cancels the load in progress
- s_valid  input  1  stream word valid
- s_data  input  DW  stream word
- s_ready  output  1  engine accepts a word
- wr_en  output  1  RAM write strobe
- wr_addr  output  AW  RAM write address
- wr_data  output  DW  RAM write data
- busy  output  1  load in progress
- done  output  1  one-cycle completion pulse
- chk_err  output  1  checksum mismatch flag

## Operation
- FSM states: IDLE, LOAD, FIN.
- **IDLE → LOAD:** on start with len≠0. Latch base, len and exp_sum; clear the index, the sum and chk_err.
- **IDLE → FIN:** on start with len=0. Latch exp_sum and clear the sum and chk_err, as above.
- **LOAD:** s_ready=1. A handshake occurs when s_valid & s_ready. Each handshake:
  - registers wr_en=1, wr_addr=(base+idx) mod 2**AW and wr_data=s_data;
  - increments idx.
- **LOAD → FIN:** on the handshake where idx = len−1.
- **FIN:** s_ready=0. Assert done for exactly one cycle and update chk_err, then return to IDLE.
- **Address wrap:** addresses wrap modulo 2**AW. With base=250, len=10 and AW=8, the write addresses are 250..255 then 0..3.
- **len=2**AW:** writes every location exactly once.
- **abort:** from LOAD or FIN, go to IDLE next cycle.
  - No done pulse; chk_err is unchanged.
  - A write already registered still completes.
  - abort has priority over a simultaneous handshake; that word is not written.
- **start while not IDLE:** ignored, including start in the same cycle as done.
- **start and abort together in IDLE:** abort wins; the start is ignored.
- **busy:** high in LOAD and FIN.

## Timing
- **Reset values:** s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, chk_err=0; FSM in IDLE.
- **Write latency:** 1 cycle from the handshake edge to wr_en/wr_addr/wr_data at the register outputs. wr_en is high for exactly one cycle per accepted word.
- **Accept latency:** s_ready rises the cycle after the start edge.
- **Throughput:** 1 word/cycle with s_valid held high. len words take len cycles in LOAD.
- **Completion:** the final wr_en and the FIN cycle coincide, so done is asserted in the same cycle as the last wr_en, one cycle after the last handshake.
- **len=0:** done is asserted 1 cycle after start.
- **Load to load:** the earliest next start is the cycle after done.
- **Reset mid-load:** all outputs return to their reset values immediately (asynchronously); the partial table is not restored.

## Configuration
- **With WL_LUT_WR_CHKSUM_EN defined:**
  - A 16-bit sum accumulates every accepted s_data, zero-extended, modulo 2**16.
  - In FIN, chk_err ← (sum ≠ exp_sum).
  - chk_err holds until the next accepted start.
- **Without the macro:**
  - No accumulator.
  - exp_sum is ignored.
  - chk_err is held at constant 0.
- The write path is identical in both builds.

## Test plan
- **Basic load.** Stimulus: reset, start with base=0x10, len=4, then data 0xA1,0xB2,0xC3,0xD4 back-to-back. Response: wr_addr 0x10..0x13 with matching wr_data; done in the same cycle as the 4th wr_en; busy low the cycle after done.
- **Wrap.** Stimulus: base=0xFE, len=4. Response: writes to 0xFE, 0xFF, 0x00, 0x01; no extra wr_en.
- **Stalls and len=0.** Stimulus: s_valid toggling 1,0,0,1,1 with len=3; separately, start with len=0. Response: exactly 3 writes, aligned 1 cycle after each handshake; with len=0, done 1 cycle after start and no wr_en.
- **Abort.** Stimulus: abort asserted during the 3rd handshake of a len=8 load. Response: only 2 writes; no done; IDLE next cycle; a new start is then accepted normally.
- **Checksum (macro defined).** Stimulus: data 0x01,0x02,0x03 with exp_sum=0x0006, then the same data with exp_sum=0x0007. Response: chk_err=0 after the first load; chk_err=1 with done after the second, holding until the next start. Without the macro, chk_err stays 0.
- **Reset mid-load and ignored start.** Stimulus: assert rst mid-burst; separately, pulse start while busy. Response: all outputs 0 immediately; the start while busy changes neither base nor len.
